fifo_rr_scheduler: RTL and testbench

//   Drains N_PORTS source FIFOs (first-word-fall-through heads, pop/empty interface) into one output

---
 rtl/fifo_rr_scheduler_if.sv | 37 +++
 rtl/fifo_rr_scheduler.sv | 159 +++++++++++++++
 tb/tb_fifo_rr_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rr_scheduler_if.sv
// rtl/fifo_rr_scheduler_if.sv - source FIFO and output stream bundle for fifo_rr_scheduler
//
// Groups every non-clock signal of the scheduler.
//   enable_i      : 0 stops new pops; the output register still drains
//   fifo_empty_i  : per-source FIFO empty flag
//   fifo_data_i   : per-source FIFO head word, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_pop_o    : per-source pop strobe, combinational, at most one-hot
//   out_data_o    : registered output word
//   out_src_o     : source index of out_data_o
//   out_valid_o   : output register holds a word
//   out_ready_i   : downstream accepts the word when out_valid_o & out_ready_i
// The master modport is the scheduler; the slave modport is the FIFOs plus the downstream link.
interface fifo_rr_scheduler_if #(
  parameter int DATA_WIDTH = 4,
  parameter int N_PORTS    = 4
);
  localparam int SRC_W = $clog2(N_PORTS);

  logic                          enable_i;
  logic [N_PORTS-1:0]            fifo_empty_i;
  logic [N_PORTS*DATA_WIDTH-1:0] fifo_data_i;
  logic [N_PORTS-1:0]            fifo_pop_o;
  logic [DATA_WIDTH-1:0]         out_data_o;
  logic [SRC_W-1:0]              out_src_o;
  logic                          out_valid_o;
  logic                          out_ready_i;

  modport master (
    input  enable_i, fifo_empty_i, fifo_data_i, out_ready_i,
    output fifo_pop_o, out_data_o, out_src_o, out_valid_o
  );

  modport slave (
    output enable_i, fifo_empty_i, fifo_data_i, out_ready_i,
    input  fifo_pop_o, out_data_o, out_src_o, out_valid_o
  );
endinterface

// File: rtl/fifo_rr_scheduler.sv
// rtl/fifo_rr_scheduler.sv - round-robin burst-limited drain of N source FIFOs into one stream
//
// Pops first-word-fall-through source FIFOs under round-robin arbitration, holding a grant for
// up to MAX_BURST consecutive words, and presents the popped word in a one-entry output register.
//   clk_i  : clock, rising edge
//   rstn_i : asynchronous active-low reset
//   bus    : fifo_rr_scheduler_if.master (FIFO pop/empty/data, output valid/ready stream, enable)
module fifo_rr_scheduler #(
  parameter int DATA_WIDTH = 4,
  parameter int N_PORTS    = 4,
  parameter int MAX_BURST  = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  fifo_rr_scheduler_if.master  bus
);

  localparam int SRC_W  = $clog2(N_PORTS);
  localparam int BCNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t            state_q, state_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]  cur_src_q, cur_src_d;
  logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic              load_en;
  logic [SRC_W-1:0]  search_start;
  logic [SRC_W-1:0]  search_idx;
  logic              found;
  logic [SRC_W-1:0]  winner;
  logic              pop_en;
  logic [SRC_W-1:0]  pop_idx;
  logic [N_PORTS-1:0] pop_vec;

  // Explicit compare so non-power-of-two N_PORTS wraps to 0 instead of overflowing into unused codes.
  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] v);
    if (v == SRC_W'(N_PORTS - 1)) begin
      return '0;
    end
    return v + SRC_W'(1);
  endfunction

  // A new word may enter the output register only if it is empty or being drained this cycle.
  assign load_en = bus.enable_i & (~bus.out_valid_o | bus.out_ready_i);

  // In SERVE the search is only consumed when cur_src has run dry, so it starts one past cur_src.
  always_comb begin
    search_start = (state_q == SERVE) ? wrap_inc(cur_src_q) : rr_ptr_q;
    found        = 1'b0;
    winner       = '0;
    search_idx   = search_start;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!found && !bus.fifo_empty_i[search_idx]) begin
        found  = 1'b1;
        winner = search_idx;
      end
      search_idx = wrap_inc(search_idx);
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_src_d   = cur_src_q;
    burst_cnt_d = burst_cnt_q;
    pop_en      = 1'b0;
    pop_idx     = cur_src_q;

    case (state_q)
      IDLE: begin
        if (load_en && found) begin
          pop_en      = 1'b1;
          pop_idx     = winner;
          cur_src_d   = winner;
          burst_cnt_d = BCNT_W'(1);
          if (MAX_BURST == 1) begin
            rr_ptr_d = wrap_inc(winner);
          end else begin
            state_d = SERVE;
          end
        end
      end

      SERVE: begin
        // With load_en low the lock is simply held, so back-pressure never costs the grant.
        if (load_en) begin
          if (!bus.fifo_empty_i[cur_src_q]) begin
            pop_en      = 1'b1;
            pop_idx     = cur_src_q;
            burst_cnt_d = burst_cnt_q + BCNT_W'(1);
            if (burst_cnt_q + BCNT_W'(1) == BCNT_W'(MAX_BURST)) begin
              rr_ptr_d = wrap_inc(cur_src_q);
              state_d  = IDLE;
            end
          end else begin
            // Early end: re-arbitrate in the same cycle so the grant change costs no bubble.
            rr_ptr_d = wrap_inc(cur_src_q);
            if (found) begin
              pop_en      = 1'b1;
              pop_idx     = winner;
              cur_src_d   = winner;
              burst_cnt_d = BCNT_W'(1);
              if (MAX_BURST == 1) begin
                rr_ptr_d = wrap_inc(winner);
                state_d  = IDLE;
              end
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop_vec = '0;
    if (rstn_i && pop_en) begin
      pop_vec[pop_idx] = 1'b1;
    end
  end

  assign bus.fifo_pop_o = pop_vec;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cur_src_q   <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_src_q   <= cur_src_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Output register: loads on a pop, otherwise empties once the downstream takes the word
  // (also with enable_i low, so a held word always drains).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bus.out_valid_o <= 1'b0;
      bus.out_data_o  <= '0;
      bus.out_src_o   <= '0;
    end else if (pop_en) begin
      bus.out_valid_o <= 1'b1;
      bus.out_data_o  <= bus.fifo_data_i[int'(pop_idx)*DATA_WIDTH +: DATA_WIDTH];
      bus.out_src_o   <= pop_idx;
    end else if (bus.out_ready_i) begin
      bus.out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb/tb_fifo_rr_scheduler.sv - directed self-checking bench for fifo_rr_scheduler
module tb_fifo_rr_scheduler;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  fifo_rr_scheduler_if #(.DATA_WIDTH(4), .N_PORTS(4)) bus_a ();
  fifo_rr_scheduler_if #(.DATA_WIDTH(4), .N_PORTS(4)) bus_b ();

  fifo_rr_scheduler #(.DATA_WIDTH(4), .N_PORTS(4), .MAX_BURST(2)) u_dut_a (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .bus   (bus_a)
  );

  fifo_rr_scheduler #(.DATA_WIDTH(4), .N_PORTS(4), .MAX_BURST(1)) u_dut_b (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .bus   (bus_b)
  );

  int total = 0;
  int passed = 0;
  int viol = 0;
  int cyc = 0;
  bit sel = 1'b0;

  logic [3:0] q [4][$];
  logic [1:0] log_src [$];
  logic [3:0] log_data [$];
  int         log_cyc [$];

  task automatic refresh();
    for (int k = 0; k < 4; k++) begin
      bus_a.fifo_empty_i[k] = (q[k].size() == 0);
      bus_b.fifo_empty_i[k] = (q[k].size() == 0);
      bus_a.fifo_data_i[k*4 +: 4] = (q[k].size() == 0) ? 4'h0 : q[k][0];
      bus_b.fifo_data_i[k*4 +: 4] = (q[k].size() == 0) ? 4'h0 : q[k][0];
    end
  endtask

  task automatic load(input int k, input int n);
    logic [1:0] src;
    logic [1:0] seq;
    src = 2'(k);
    for (int s = 0; s < n; s++) begin
      seq = 2'(s);
      q[k].push_back({src, seq});
    end
  endtask

  task automatic clear_log();
    log_src.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic tick();
    logic [3:0] p;
    logic [3:0] emp;
    logic       ov;
    logic       ordy;
    logic [3:0] od;
    logic [1:0] os;
    @(negedge clk_i);
    if (!sel) begin
      p = bus_a.fifo_pop_o; emp = bus_a.fifo_empty_i; ov = bus_a.out_valid_o;
      ordy = bus_a.out_ready_i; od = bus_a.out_data_o; os = bus_a.out_src_o;
    end else begin
      p = bus_b.fifo_pop_o; emp = bus_b.fifo_empty_i; ov = bus_b.out_valid_o;
      ordy = bus_b.out_ready_i; od = bus_b.out_data_o; os = bus_b.out_src_o;
    end
    if ($countones(p) > 1 || (p & emp) != 4'b0) viol++;
    if (ov && ordy) begin
      log_src.push_back(os);
      log_data.push_back(od);
      log_cyc.push_back(cyc);
    end
    @(posedge clk_i);
    #1;
    cyc++;
    for (int k = 0; k < 4; k++) begin
      if (p[k] && q[k].size() > 0) void'(q[k].pop_front());
    end
    refresh();
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    bus_a.enable_i = 1'b0;
    bus_b.enable_i = 1'b0;
    bus_a.out_ready_i = 1'b1;
    bus_b.out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) q[k].delete();
    refresh();
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    clear_log();
  endtask

  task automatic collect(input int n);
    for (int c = 0; c < 40 && log_src.size() < n; c++) tick();
  endtask

  task automatic check_gapless(input string name, input int n);
    bit ok;
    ok = (log_cyc.size() >= n);
    for (int i = 0; ok && i + 1 < n; i++) begin
      if (log_cyc[i+1] != log_cyc[i] + 1) ok = 1'b0;
    end
    total++;
    if (!ok) $display("FAIL %s: words not on consecutive cycles (got %0d words, required %0d back-to-back)", name, log_cyc.size(), n);
    else passed++;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    sel = 1'b0;
    bus_b.enable_i = 1'b0;
    bus_b.out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin q[k].delete(); load(k, 1); end
    refresh();
    bus_a.enable_i = 1'b1;
    bus_a.out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    total++;
    if (bus_a.fifo_pop_o !== 4'b0000) $display("FAIL reset_pop: got %b required 0000", bus_a.fifo_pop_o);
    else passed++;
    total++;
    if (bus_a.out_valid_o !== 1'b0) $display("FAIL reset_valid: got %b required 0", bus_a.out_valid_o);
    else passed++;
    total++;
    if (bus_a.out_data_o !== 4'h0 || bus_a.out_src_o !== 2'd0)
      $display("FAIL reset_data_src: got %h/%0d required 0/0", bus_a.out_data_o, bus_a.out_src_o);
    else passed++;
    rstn_i = 1'b1;
    #1;
    total++;
    if (bus_a.fifo_pop_o !== 4'b0001) $display("FAIL reset_first_pop: got %b required 0001", bus_a.fifo_pop_o);
    else passed++;
    tick();
    total++;
    if (bus_a.out_valid_o !== 1'b1 || bus_a.out_src_o !== 2'd0 || bus_a.out_data_o !== 4'h0)
      $display("FAIL reset_first_word: got v=%b src=%0d data=%h required v=1 src=0 data=0",
               bus_a.out_valid_o, bus_a.out_src_o, bus_a.out_data_o);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [1:0] es [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
    logic [3:0] ed [12] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h8, 4'h9, 4'hC, 4'hD, 4'h2, 4'h6, 4'hA, 4'hE};
    sel = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) load(k, 3);
    refresh();
    bus_a.enable_i = 1'b1;
    collect(12);
    for (int i = 0; i < 12; i++) begin
      total++;
      if (i >= log_src.size() || log_src[i] !== es[i] || log_data[i] !== ed[i])
        $display("FAIL rr_word%0d: got src=%0d data=%h required src=%0d data=%h", i,
                 (i < log_src.size()) ? log_src[i] : 2'bxx, (i < log_data.size()) ? log_data[i] : 4'hx, es[i], ed[i]);
      else passed++;
    end
    check_gapless("rr_no_gaps", 12);
  endtask

  task automatic test_early_end();
    logic [1:0] es [5] = '{2, 3, 3, 0, 0};
    logic [3:0] ed [5] = '{4'h8, 4'hC, 4'hD, 4'h0, 4'h1};
    sel = 1'b0;
    do_reset();
    // A single word on source 1 ends its burst early and leaves rr_ptr at 2.
    load(1, 1);
    refresh();
    bus_a.enable_i = 1'b1;
    repeat (4) tick();
    bus_a.enable_i = 1'b0;
    clear_log();
    load(0, 4); load(1, 4); load(2, 1); load(3, 4);
    refresh();
    bus_a.enable_i = 1'b1;
    collect(5);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i >= log_src.size() || log_src[i] !== es[i] || log_data[i] !== ed[i])
        $display("FAIL early_word%0d: got src=%0d data=%h required src=%0d data=%h", i,
                 (i < log_src.size()) ? log_src[i] : 2'bxx, (i < log_data.size()) ? log_data[i] : 4'hx, es[i], ed[i]);
      else passed++;
    end
    check_gapless("early_no_bubble", 5);
  endtask

  task automatic test_backpressure();
    logic [1:0] es [4] = '{0, 0, 1, 1};
    logic [3:0] ed [4] = '{4'h0, 4'h1, 4'h4, 4'h5};
    sel = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) load(k, 4);
    refresh();
    bus_a.enable_i = 1'b1;
    tick();
    bus_a.out_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (bus_a.out_valid_o !== 1'b1 || bus_a.out_data_o !== 4'h0 || bus_a.out_src_o !== 2'd0 || bus_a.fifo_pop_o !== 4'b0000)
        $display("FAIL bp_hold%0d: got v=%b data=%h src=%0d pop=%b required v=1 data=0 src=0 pop=0000",
                 c, bus_a.out_valid_o, bus_a.out_data_o, bus_a.out_src_o, bus_a.fifo_pop_o);
      else passed++;
    end
    bus_a.out_ready_i = 1'b1;
    #1;
    total++;
    if (bus_a.fifo_pop_o !== 4'b0001) $display("FAIL bp_resume_pop: got %b required 0001", bus_a.fifo_pop_o);
    else passed++;
    collect(4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= log_src.size() || log_src[i] !== es[i] || log_data[i] !== ed[i])
        $display("FAIL bp_word%0d: got src=%0d data=%h required src=%0d data=%h", i,
                 (i < log_src.size()) ? log_src[i] : 2'bxx, (i < log_data.size()) ? log_data[i] : 4'hx, es[i], ed[i]);
      else passed++;
    end
  endtask

  task automatic test_enable();
    logic [1:0] es [4] = '{0, 0, 1, 1};
    logic [3:0] ed [4] = '{4'h0, 4'h1, 4'h4, 4'h5};
    sel = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) load(k, 4);
    refresh();
    bus_a.enable_i = 1'b1;
    tick();
    bus_a.enable_i = 1'b0;
    #1;
    total++;
    if (bus_a.fifo_pop_o !== 4'b0000) $display("FAIL en_off_pop: got %b required 0000", bus_a.fifo_pop_o);
    else passed++;
    tick();
    total++;
    if (bus_a.out_valid_o !== 1'b0) $display("FAIL en_drain_valid: got %b required 0", bus_a.out_valid_o);
    else passed++;
    repeat (2) tick();
    total++;
    if (bus_a.out_valid_o !== 1'b0 || bus_a.fifo_pop_o !== 4'b0000)
      $display("FAIL en_idle: got v=%b pop=%b required v=0 pop=0000", bus_a.out_valid_o, bus_a.fifo_pop_o);
    else passed++;
    bus_a.enable_i = 1'b1;
    #1;
    total++;
    if (bus_a.fifo_pop_o !== 4'b0001) $display("FAIL en_lock_pop: got %b required 0001", bus_a.fifo_pop_o);
    else passed++;
    collect(4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= log_src.size() || log_src[i] !== es[i] || log_data[i] !== ed[i])
        $display("FAIL en_word%0d: got src=%0d data=%h required src=%0d data=%h", i,
                 (i < log_src.size()) ? log_src[i] : 2'bxx, (i < log_data.size()) ? log_data[i] : 4'hx, es[i], ed[i]);
      else passed++;
    end
  endtask

  task automatic test_burst1();
    logic [1:0] es [4] = '{1, 3, 1, 3};
    logic [3:0] ed [4] = '{4'h4, 4'hC, 4'h5, 4'hD};
    do_reset();
    sel = 1'b1;
    load(1, 2);
    load(3, 2);
    refresh();
    bus_b.enable_i = 1'b1;
    collect(4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= log_src.size() || log_src[i] !== es[i] || log_data[i] !== ed[i])
        $display("FAIL b1_word%0d: got src=%0d data=%h required src=%0d data=%h", i,
                 (i < log_src.size()) ? log_src[i] : 2'bxx, (i < log_data.size()) ? log_data[i] : 4'hx, es[i], ed[i]);
      else passed++;
    end
    check_gapless("b1_no_gaps", 4);
    bus_b.enable_i = 1'b0;
    sel = 1'b0;
  endtask

  task automatic test_invariants();
    total++;
    if (viol !== 0) $display("FAIL pop_invariants: got %0d bad pop cycles required 0", viol);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_early_end();
    test_backpressure();
    test_enable();
    test_burst1();
    test_invariants();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
